dp_scheduler: RTL and testbench

DP_SCHEDULER -- requirements
Module: dp_scheduler

---
 rtl/dp_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_dp_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dp_scheduler.sv
// Two-requester round-robin front end that issues one op at a time to the datapath and returns a done pulse.
// Legal op: PULSE_CYC issue cycles + 3..DRAIN_MAX drain cycles + 1 resp cycle; ready only in IDLE, so requesters stall until done.
module dp_scheduler #(
    parameter int PULSE_CYC = 3,
    parameter int DRAIN_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [2:0] a_op,
    input  logic [7:0] a_data,
    output logic       a_ready,
    output logic       a_done,
    input  logic       b_valid,
    input  logic [2:0] b_op,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       b_done,
    output logic       resp_ovf,
    output logic       resp_err,
    output logic       resp_timeout,
    output logic       dp_new_instruction,
    output logic [2:0] dp_instruction,
    output logic [7:0] dp_data,
    input  logic       dp_ready,
    input  logic       dp_overflow
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_SUB     = 3'd2;
    localparam logic [2:0] OP_LAST    = 3'd4;
    localparam logic [2:0] INSTR_NOP  = 3'b101;
    localparam logic [3:0] ISSUE_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);
    localparam logic [3:0] READY_LAG  = 4'd2;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       owner_q, owner_d;
    logic [2:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       dp_new_q, dp_new_d;
    logic [2:0] dp_instr_q, dp_instr_d;
    logic [7:0] dp_data_q, dp_data_d;
    logic       a_done_q, a_done_d;
    logic       b_done_q, b_done_d;
    logic       rovf_q, rovf_d;
    logic       rerr_q, rerr_d;
    logic       rto_q, rto_d;

    logic       grant_b;
    logic       accept;
    logic [2:0] sel_op;
    logic [7:0] sel_data;

    // B wins when it is the only requester or when the pointer favours it.
    assign grant_b  = b_valid & (~a_valid | ptr_q);
    assign a_ready  = (state_q == IDLE) & a_valid & ~grant_b;
    assign b_ready  = (state_q == IDLE) & grant_b;
    assign accept   = a_ready | b_ready;
    assign sel_op   = grant_b ? b_op : a_op;
    assign sel_data = grant_b ? b_data : a_data;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        dp_new_d   = dp_new_q;
        dp_instr_d = dp_instr_q;
        dp_data_d  = dp_data_q;
        a_done_d   = 1'b0;
        b_done_d   = 1'b0;
        rovf_d     = 1'b0;
        rerr_d     = 1'b0;
        rto_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d   = ~ptr_q;
                    owner_d = grant_b;
                    op_d    = sel_op;
                    cnt_d   = 4'd0;
                    ovf_d   = 1'b0;
                    if (sel_op <= OP_LAST) begin
                        state_d    = ISSUE;
                        dp_new_d   = 1'b1;
                        dp_instr_d = sel_op;
                        dp_data_d  = sel_data;
                    end else begin
                        // Illegal op never touches the datapath.
                        state_d  = RESP;
                        a_done_d = ~grant_b;
                        b_done_d = grant_b;
                        rerr_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == ISSUE_LAST) begin
                    state_d    = DRAIN;
                    cnt_d      = 4'd0;
                    dp_new_d   = 1'b0;
                    dp_instr_d = INSTR_NOP;
                    ovf_d      = ((op_q == OP_ADD) || (op_q == OP_SUB)) & dp_overflow;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DRAIN: begin
                // dp_ready lags the new instruction, so the first two drain cycles see a stale value.
                if ((cnt_q >= READY_LAG) && dp_ready) begin
                    state_d  = RESP;
                    a_done_d = ~owner_q;
                    b_done_d = owner_q;
                    rovf_d   = ovf_q;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d  = RESP;
                    a_done_d = ~owner_q;
                    b_done_d = owner_q;
                    rovf_d   = ovf_q;
                    rto_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            op_q       <= 3'd0;
            cnt_q      <= 4'd0;
            ovf_q      <= 1'b0;
            dp_new_q   <= 1'b0;
            dp_instr_q <= INSTR_NOP;
            dp_data_q  <= 8'd0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            rovf_q     <= 1'b0;
            rerr_q     <= 1'b0;
            rto_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            dp_new_q   <= dp_new_d;
            dp_instr_q <= dp_instr_d;
            dp_data_q  <= dp_data_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            rovf_q     <= rovf_d;
            rerr_q     <= rerr_d;
            rto_q      <= rto_d;
        end
    end

    assign a_done             = a_done_q;
    assign b_done             = b_done_q;
    assign resp_ovf           = rovf_q;
    assign resp_err           = rerr_q;
    assign resp_timeout       = rto_q;
    assign dp_new_instruction = dp_new_q;
    assign dp_instruction     = dp_instr_q;
    assign dp_data            = dp_data_q;

endmodule

// File: tb/tb_dp_scheduler.sv
// Directed bench for dp_scheduler: arbitration, issue/drain timing, response flags and async reset.
module tb_dp_scheduler;
    localparam int P    = 3;
    localparam int DMAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [2:0] a_op, b_op;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, a_done, b_done;
    logic       resp_ovf, resp_err, resp_timeout;
    logic       dp_new_instruction;
    logic [2:0] dp_instruction;
    logic [7:0] dp_data;
    logic       dp_ready, dp_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dp_scheduler #(.PULSE_CYC(P), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
        .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
        .resp_ovf(resp_ovf), .resp_err(resp_err), .resp_timeout(resp_timeout),
        .dp_new_instruction(dp_new_instruction), .dp_instruction(dp_instruction),
        .dp_data(dp_data), .dp_ready(dp_ready), .dp_overflow(dp_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one transaction from an IDLE cycle. A gets dat, B gets ~dat so the owner is visible on dp_data.
    // rdy_at: drain cycle where dp_ready rises after the stale window (0 = never).
    task automatic issue(input logic av, input logic bv, input logic [2:0] op, input logic [7:0] dat,
                         input logic exp_b, input int rdy_at, input logic ovf);
        logic       legal, e_to, e_ovf;
        int         dlen, done_cyc, d;
        logic [7:0] edat;
        legal    = (op <= 3'd4);
        e_to     = (rdy_at == 0) || (rdy_at > DMAX);
        dlen     = e_to ? DMAX : ((rdy_at < 3) ? 3 : rdy_at);
        done_cyc = legal ? (P + dlen + 1) : 1;
        edat     = exp_b ? ~dat : dat;
        e_ovf    = legal && ((op == 3'd1) || (op == 3'd2)) && ovf;
        @(negedge clk);
        a_valid = av; b_valid = bv; a_op = op; b_op = op; a_data = dat; b_data = ~dat;
        dp_ready = 1'b1; dp_overflow = 1'b0;
        #1;
        chk($sformatf("a_ready op%0d", op), a_ready, av && !exp_b);
        chk($sformatf("b_ready op%0d", op), b_ready, exp_b);
        for (int i = 1; i <= done_cyc; i++) begin
            @(negedge clk);
            d = i - P;
            if (i == 1) begin
                a_op = ~a_op; b_op = ~b_op; a_data = a_data ^ 8'h5A; b_data = b_data ^ 8'hA5;
                #1;
                chk("busy a_ready", a_ready, 1'b0);
                chk("busy b_ready", b_ready, 1'b0);
            end
            dp_ready    = (i <= P) ? 1'b0 : ((d <= 2) ? 1'b1 : (rdy_at != 0 && d >= rdy_at));
            dp_overflow = (i == P) ? ovf : ~ovf;
            chk($sformatf("dp_new op%0d c%0d", op, i), dp_new_instruction, legal && i <= P);
            chk($sformatf("dp_instr op%0d c%0d", op, i), dp_instruction, (legal && i <= P) ? op : 3'd5);
            if (legal && i <= P + dlen)
                chk($sformatf("dp_data op%0d c%0d", op, i), dp_data, edat);
            chk($sformatf("a_done op%0d c%0d", op, i), a_done, (i == done_cyc) && !exp_b);
            chk($sformatf("b_done op%0d c%0d", op, i), b_done, (i == done_cyc) && exp_b);
            chk($sformatf("resp_ovf op%0d c%0d", op, i), resp_ovf, (i == done_cyc) && e_ovf);
            chk($sformatf("resp_err op%0d c%0d", op, i), resp_err, (i == done_cyc) && !legal);
            chk($sformatf("resp_to op%0d c%0d", op, i), resp_timeout, (i == done_cyc) && legal && e_to);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a_valid = 0; b_valid = 0; a_op = 0; b_op = 0; a_data = 0; b_data = 0;
        dp_ready = 1'b1; dp_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst dp_new", dp_new_instruction, 1'b0);
        chk("rst dp_instr", dp_instruction, 3'd5);
        chk("rst dp_data", dp_data, 8'd0);
        chk("rst a_done", a_done, 1'b0);
        chk("rst b_done", b_done, 1'b0);
        chk("rst resp_ovf", resp_ovf, 1'b0);
        chk("rst resp_err", resp_err, 1'b0);
        chk("rst resp_to", resp_timeout, 1'b0);
        rst = 1'b0;

        // Both valid: grants alternate A, B, A, B.
        issue(1, 1, 3'd1, 8'h21, 0, 3, 1);
        issue(1, 1, 3'd2, 8'h30, 1, 4, 0);
        issue(1, 1, 3'd3, 8'h47, 0, 3, 1);
        issue(1, 1, 3'd4, 8'h58, 1, 5, 0);
        // A only, LOAD 0x12, ready in third drain cycle.
        issue(1, 0, 3'd4, 8'h12, 0, 3, 0);
        // B ADD with overflow, then B DISP with overflow ignored.
        issue(0, 1, 3'd1, 8'h9C, 1, 3, 1);
        issue(0, 1, 3'd3, 8'h9D, 1, 3, 1);
        // Illegal op from A.
        issue(1, 0, 3'd6, 8'hEE, 0, 3, 0);
        // Timeout, then ready arriving on the last allowed drain cycle.
        issue(1, 0, 3'd4, 8'h7F, 0, 0, 0);
        issue(0, 1, 3'd0, 8'h01, 1, 15, 0);
        // SUB with overflow high everywhere except the last issue cycle.
        issue(1, 0, 3'd2, 8'hC3, 0, 4, 0);
        issue(0, 1, 3'd7, 8'h00, 1, 3, 0);
        issue(1, 0, 3'd5, 8'h11, 0, 3, 0);

        // Pointer now favours B; reset during the second issue cycle.
        @(negedge clk);
        a_valid = 1; b_valid = 1; a_op = 3'd1; b_op = 3'd1; a_data = 8'h44; b_data = 8'h55; dp_ready = 1'b0;
        #1;
        chk("pre-rst b_ready", b_ready, 1'b1);
        chk("pre-rst a_ready", a_ready, 1'b0);
        @(negedge clk);
        chk("pre-rst dp_new c1", dp_new_instruction, 1'b1);
        chk("pre-rst dp_data c1", dp_data, 8'h55);
        @(negedge clk);
        chk("pre-rst dp_new c2", dp_new_instruction, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst dp_new", dp_new_instruction, 1'b0);
        chk("midrst dp_instr", dp_instruction, 3'd5);
        chk("midrst dp_data", dp_data, 8'd0);
        chk("midrst b_done", b_done, 1'b0);
        @(negedge clk);
        chk("rst hold a_done", a_done, 1'b0);
        chk("rst hold b_done", b_done, 1'b0);
        rst = 1'b0;
        #1;
        chk("post-rst a_ready", a_ready, 1'b1);
        chk("post-rst b_ready", b_ready, 1'b0);
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        chk("post-rst dp_new", dp_new_instruction, 1'b0);
        chk("post-rst b_done", b_done, 1'b0);
        issue(1, 1, 3'd2, 8'h66, 0, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
